// File: rtl/inst_stream_tx_pkg.sv
// inst_stream_tx_pkg
//   Shared definitions for the PE instruction/operand transmitter:
//   default widths (which must match the PE instruction memory), the
//   controller state encoding and the fixed SETTLE wait length.
package inst_stream_tx_pkg;

    localparam int DEF_INST_WIDTH    = 32;
    localparam int DEF_IM_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH    = 16;

    // Cycles spent in SETTLE. They cover the PE's registered
    // instruction-memory write pipeline.
    localparam int SETTLE_CYCLES = 2;

    typedef enum logic [1:0] {
        ST_INST   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DATA   = 2'd2,
        ST_GAP    = 2'd3
    } tx_state_e;

endpackage

// File: rtl/inst_stream_tx_gap_ctr.sv
// inst_stream_tx_gap_ctr
//   Loadable down-counter used for the SETTLE and GAP waits.
//   A load sets the counter to load_val for the next cycle. After that
//   it counts down to zero and stays there.
//   done is high on the last cycle of a wait, which is when the count is
//   1. It is also high at 0, so a zero-length load cannot stall.
// Ports:
//   clk      : clock
//   rst      : synchronous active-high reset (count -> 0)
//   load     : load load_val this cycle
//   load_val : wait length in cycles
//   done     : current cycle is the final cycle of the wait
module inst_stream_tx_gap_ctr
    import inst_stream_tx_pkg::*;
#(
    parameter int W = DEF_IM_ADDR_WIDTH + 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt <= W'(1));

endmodule

// File: rtl/inst_stream_tx.sv
// inst_stream_tx
//   Transmit-side partner of the PE instruction memory.
//   It first forwards a host program to the PE as a stream of nonzero
//   words on pe_inst. Then it streams operands in pe_valid bursts.
//   Every burst is followed by a valid-low gap of N+GAP_EXTRA cycles,
//   during which the PE replays its N-word program.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   host_inst/_valid/_last/_ready : program load handshake from host
//   prog_err             : one-cycle pulse, a host word was rejected
//   prog_len             : accepted instruction count N
//   s_data/s_valid/s_ready : upstream operand stream
//   pe_inst              : instruction stream to PE (0 = idle)
//   pe_data/pe_valid     : operand stream to PE
//   busy                 : high outside the INST state
module inst_stream_tx
    import inst_stream_tx_pkg::*;
#(
    parameter int INST_WIDTH    = DEF_INST_WIDTH,
    parameter int IM_ADDR_WIDTH = DEF_IM_ADDR_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int BURST_LEN     = 8,
    parameter int GAP_EXTRA     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INST_WIDTH-1:0]    host_inst,
    input  logic                     host_inst_valid,
    input  logic                     host_inst_last,
    output logic                     host_inst_ready,
    output logic                     prog_err,
    output logic [IM_ADDR_WIDTH-1:0] prog_len,
    input  logic [DATA_WIDTH-1:0]    s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [INST_WIDTH-1:0]    pe_inst,
    output logic [DATA_WIDTH-1:0]    pe_data,
    output logic                     pe_valid,
    output logic                     busy
);

    // The gap counter holds up to 2^IM_ADDR_WIDTH-1 + GAP_EXTRA without wrapping.
    localparam int CW = IM_ADDR_WIDTH + 2;
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam logic [IM_ADDR_WIDTH-1:0] N_MAX = '1;

    tx_state_e state, state_nxt;

    logic [IM_ADDR_WIDTH-1:0] n_cnt;
    logic [IM_ADDR_WIDTH-1:0] n_upd;
    logic [BW-1:0]            beat_cnt;

    logic inst_acc, inst_zero, inst_full, inst_good, inst_err;
    logic beat, burst_full, burst_early;

    logic          ctr_load;
    logic [CW-1:0] ctr_load_val;
    logic          ctr_done;
    logic [CW-1:0] gap_len;

    // Program-load decode
    assign inst_acc  = (state == ST_INST) && host_inst_valid;
    assign inst_zero = (host_inst == '0);
    assign inst_full = (n_cnt == N_MAX);
    assign inst_good = inst_acc && !inst_zero && !inst_full;
    assign n_upd     = n_cnt + {{(IM_ADDR_WIDTH-1){1'b0}}, inst_good};
    // A zero word is dropped because the PE would silently ignore it.
    // A "last" that leaves an empty program is also rejected.
    assign inst_err  = inst_acc &&
                       (inst_zero || inst_full || (host_inst_last && (n_upd == '0)));

    // Burst decode
    assign beat        = (state == ST_DATA) && s_valid;
    assign burst_full  = beat && (beat_cnt == BW'(BURST_LEN - 1));
    assign burst_early = (state == ST_DATA) && !s_valid && (beat_cnt != '0);

    // A full burst enters GAP while pe_valid is still high from its last
    // beat. An early end enters GAP one cycle after pe_valid has already
    // dropped, so it waits one cycle less. Either way the PE sees exactly
    // N+GAP_EXTRA low cycles when upstream is ready again.
    assign gap_len = CW'(n_cnt) + CW'(GAP_EXTRA);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ctr_load     = 1'b0;
        ctr_load_val = '0;
        case (state)
            ST_INST: begin
                if (inst_acc && host_inst_last && (n_upd != '0)) begin
                    state_nxt    = ST_SETTLE;
                    ctr_load     = 1'b1;
                    ctr_load_val = CW'(SETTLE_CYCLES);
                end
            end
            ST_SETTLE: begin
                if (ctr_done) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (burst_full) begin
                    state_nxt    = ST_GAP;
                    ctr_load     = 1'b1;
                    ctr_load_val = gap_len;
                end else if (burst_early) begin
                    state_nxt    = ST_GAP;
                    ctr_load     = 1'b1;
                    ctr_load_val = gap_len - CW'(1);
                end
            end
            ST_GAP: begin
                if (ctr_done) begin
                    state_nxt = ST_DATA;
                end
            end
            default: state_nxt = ST_INST;
        endcase
    end

    inst_stream_tx_gap_ctr #(
        .W (CW)
    ) u_gap_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (ctr_load),
        .load_val (ctr_load_val),
        .done     (ctr_done)
    );

    // Registered outputs: one cycle behind the accepting handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            n_cnt    <= '0;
            beat_cnt <= '0;
            prog_err <= 1'b0;
            pe_inst  <= '0;
            pe_valid <= 1'b0;
            pe_data  <= '0;
        end else begin
            n_cnt    <= n_upd;
            prog_err <= inst_err;
            pe_inst  <= inst_good ? host_inst : '0;
            pe_valid <= beat;
            if (beat) begin
                pe_data <= s_data;
            end
            if (burst_full || burst_early) begin
                beat_cnt <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + BW'(1);
            end
        end
    end

    assign host_inst_ready = (state == ST_INST);
    assign s_ready         = (state == ST_DATA);
    assign busy            = (state != ST_INST);
    assign prog_len        = n_cnt;

endmodule

// File: tb/tb_inst_stream_tx.sv
module tb_inst_stream_tx;

    localparam int IW = 32;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int BL = 8;
    localparam int GX = 2;
    localparam int NMAX = (1 << AW) - 1;

    logic          clk;
    logic          rst;
    logic [IW-1:0] host_inst;
    logic          host_inst_valid;
    logic          host_inst_last;
    logic          host_inst_ready;
    logic          prog_err;
    logic [AW-1:0] prog_len;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [IW-1:0] pe_inst;
    logic [DW-1:0] pe_data;
    logic          pe_valid;
    logic          busy;

    inst_stream_tx #(
        .INST_WIDTH    (IW),
        .IM_ADDR_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .BURST_LEN     (BL),
        .GAP_EXTRA     (GX)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .host_inst       (host_inst),
        .host_inst_valid (host_inst_valid),
        .host_inst_last  (host_inst_last),
        .host_inst_ready (host_inst_ready),
        .prog_err        (prog_err),
        .prog_len        (prog_len),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .pe_inst         (pe_inst),
        .pe_data         (pe_data),
        .pe_valid        (pe_valid),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: program phase tracks the accepted count and when
    // data may start. The data phase is described by the pe_valid
    // timeline: a burst continues while beats keep coming and the burst
    // is below BURST_LEN. A new burst may start only after pe_valid has
    // been low for at least N+GAP_EXTRA cycles.
    logic          m_inst;
    int            m_n;
    longint        cyc;
    longint        t_open;
    int            m_low;
    int            m_beats;
    logic          m_prev_acc;
    int            m_acc_cnt;
    logic [IW-1:0] e_inst;
    logic          e_err;
    logic [DW-1:0] e_data;
    logic          e_valid;
    logic          e_ready;

    logic rec;
    logic trace[$];
    int   runs[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_inst     = 1'b1;
        m_n        = 0;
        t_open     = 64'h7fff_ffff;
        m_low      = 1000;
        m_beats    = 0;
        m_prev_acc = 1'b0;
        e_inst     = '0;
        e_err      = 1'b0;
        e_data     = '0;
        e_valid    = 1'b0;
        e_ready    = 1'b0;
    endtask

    task automatic check_outputs();
        chk("pe_inst", 64'(pe_inst), 64'(e_inst));
        chk("prog_err", 64'(prog_err), 64'(e_err));
        chk("prog_len", 64'(prog_len), 64'(m_n));
        chk("pe_valid", 64'(pe_valid), 64'(e_valid));
        chk("pe_data", 64'(pe_data), 64'(e_data));
        chk("s_ready", 64'(s_ready), 64'(e_ready));
        chk("host_inst_ready", 64'(host_inst_ready), 64'(m_inst));
        chk("busy", 64'(busy), 64'(!m_inst));
    endtask

    // One clock: drive inputs, advance the model, clock, compare.
    task automatic step(input logic r, input logic hv, input logic [IW-1:0] hw,
                        input logic hl, input logic sv, input logic [DW-1:0] sd);
        logic acc_i, good, acc_d;
        int   nn;
        rst             = r;
        host_inst_valid = hv;
        host_inst       = hw;
        host_inst_last  = hl;
        s_valid         = sv;
        s_data          = sd;
        if (r) begin
            model_reset();
        end else begin
            acc_i  = m_inst && hv;
            good   = acc_i && (hw != '0) && (m_n < NMAX);
            nn     = m_n + (good ? 1 : 0);
            e_err  = acc_i && ((hw == '0) || (m_n == NMAX) || (hl && nn == 0));
            e_inst = good ? hw : '0;
            if (acc_i && hl && nn != 0) begin
                m_inst = 1'b0;
                t_open = cyc + 3;
            end
            m_n = nn;
            acc_d = e_ready && sv;
            if (acc_d) begin
                e_data = sd;
                m_acc_cnt++;
            end
            m_beats    = acc_d ? (m_prev_acc ? m_beats + 1 : 1) : 0;
            m_prev_acc = acc_d;
            e_valid    = acc_d;
            m_low      = e_valid ? 0 : ((m_low < 1000) ? m_low + 1 : m_low);
        end
        cyc++;
        e_ready = !r && (cyc >= t_open) &&
                  ((m_prev_acc && m_beats < BL) || (m_low >= m_n + GX));
        @(posedge clk);
        #1;
        check_outputs();
        if (rec) trace.push_back(pe_valid);
    endtask

    task automatic load(input logic [IW-1:0] w, input logic last);
        step(1'b0, 1'b1, w, last, 1'b0, '0);
    endtask

    task automatic idle(input int n, input logic sv);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, sv, DW'($urandom));
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic random_traffic(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'($urandom), IW'($urandom), 1'($urandom),
                 ($urandom_range(0, 9) < 7), DW'($urandom));
    endtask

    task automatic compute_runs();
        logic seen, lv;
        int   len;
        seen = 1'b0;
        lv   = 1'b0;
        len  = 0;
        runs.delete();
        foreach (trace[i]) begin
            if (!seen) begin
                if (trace[i]) begin
                    seen = 1'b1;
                    lv   = 1'b1;
                    len  = 1;
                end
            end else if (trace[i] == lv) begin
                len++;
            end else begin
                runs.push_back(len);
                lv  = trace[i];
                len = 1;
            end
        end
        if (seen && lv) runs.push_back(len);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_runs[5];
        int exp_early[2];
        int n_rand;
        exp_runs  = '{8, 5, 8, 5, 4};
        exp_early = '{3, 5};
        cyc       = 0;
        m_acc_cnt = 0;
        rec       = 1'b0;
        rst = 1'b1; host_inst = '0; host_inst_valid = 1'b0; host_inst_last = 1'b0;
        s_data = '0; s_valid = 1'b0;
        model_reset();

        // Reset values, then the three-word program 0x11,0x22,0x33
        do_reset();
        do_reset();
        load(32'h11, 1'b0);
        load(32'h22, 1'b0);
        load(32'h33, 1'b1);
        chk("len_3", 64'(prog_len), 64'd3);

        // 20 words with continuous s_valid: bursts of 8 / gap 5
        rec = 1'b1;
        trace.delete();
        m_acc_cnt = 0;
        for (int i = 0; i < 100 && m_acc_cnt < 20; i++)
            step(1'b0, 1'b0, '0, 1'b0, 1'b1, DW'($urandom));
        chk("burst20_accepted", 64'(m_acc_cnt), 64'd20);
        idle(6, 1'b0);
        rec = 1'b0;
        compute_runs();
        chk("burst20_run_count", 64'(runs.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            if (i < runs.size()) chk("burst20_run", 64'(runs[i]), 64'(exp_runs[i]));

        // Zero word in the middle of the program
        do_reset();
        load(32'h11, 1'b0);
        load(32'h0, 1'b0);
        load(32'h22, 1'b1);
        chk("len_2", 64'(prog_len), 64'd2);
        idle(6, 1'b1);

        // Sixteen nonzero words: the last one overflows the memory
        do_reset();
        for (int i = 0; i < 16; i++) load(IW'($urandom) | 32'h1, (i == 15));
        chk("len_15", 64'(prog_len), 64'd15);
        random_traffic(150);

        // "last" on an empty program, then a real one-word program
        do_reset();
        load(32'h0, 1'b1);
        chk("empty_last_stays", 64'(host_inst_ready), 64'd1);
        load(32'h5, 1'b1);
        random_traffic(80);

        // Random program with occasional zero words
        do_reset();
        n_rand = $urandom_range(1, 15);
        for (int i = 0; i < n_rand; i++)
            load(($urandom_range(0, 3) == 0) ? 32'h0 : (IW'($urandom) | 32'h100),
                 (i == n_rand - 1));
        load(32'h77, 1'b1);
        random_traffic(150);

        // Early burst end after 3 beats with N=3, then reset inside a gap
        do_reset();
        load(32'hA1, 1'b0);
        load(32'hA2, 1'b0);
        load(32'hA3, 1'b1);
        idle(2, 1'b0);
        rec = 1'b1;
        trace.delete();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b1, DW'($urandom));
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b1, DW'($urandom));
        rec = 1'b0;
        compute_runs();
        for (int i = 0; i < 2; i++)
            if (i < runs.size()) chk("early_run", 64'(runs[i]), 64'(exp_early[i]));
        chk("early_run_present", 64'(runs.size() >= 2), 64'd1);
        random_traffic(100);
        for (int i = 0; i < 50 && !(!e_ready && !m_prev_acc && !m_inst); i++)
            step(1'b0, 1'b0, '0, 1'b0, 1'b1, DW'($urandom));
        chk("reached_gap", 64'(!e_ready && !m_prev_acc && !m_inst), 64'd1);
        chk("gap_s_ready_low", 64'(s_ready), 64'd0);
        do_reset();
        chk("rst_ready", 64'(host_inst_ready), 64'd1);
        chk("rst_pe_data", 64'(pe_data), 64'd0);
        load(32'h9, 1'b1);
        idle(10, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_stream_tx.md
Name: inst_stream_tx

Overview:
- Transmit-side partner of the PE instruction memory.
- Takes a program from the host controller and forwards it as a nonzero instruction stream on pe_inst, which is the PE's instruction input.
- Then streams operand data to the PE in bursts framed by pe_valid.
- Guarantees the valid-low gap the PE needs after each burst to replay its whole program before the next burst starts.

Parameters:
- INST_WIDTH, 32, instruction word width; must match the PE instruction memory.
- IM_ADDR_WIDTH, 4, PE instruction memory address width; maximum program length is 2^IM_ADDR_WIDTH-1 (15).
- DATA_WIDTH, 16, operand word width.
- BURST_LEN, 8, maximum data beats per pe_valid burst (>=1).
- GAP_EXTRA, 2, extra idle cycles added after each burst beyond the program length N.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- host_inst  in  INST_WIDTH  program word from host
- host_inst_valid  in  1  host word valid
- host_inst_last  in  1  marks final program word
- host_inst_ready  out  1  word accepted when valid&ready
- prog_err  out  1  one-cycle pulse: word rejected
- prog_len  out  IM_ADDR_WIDTH  accepted instruction count N
- s_data  in  DATA_WIDTH  upstream operand
- s_valid  in  1  upstream valid
- s_ready  out  1  upstream ready
- pe_inst  out  INST_WIDTH  instruction stream to PE; 0 = idle
- pe_data  out  DATA_WIDTH  operand to PE
- pe_valid  out  1  PE data valid
- busy  out  1  high outside the INST state

Behaviour:
- Reset (rst high at a clk edge) applies to all outputs at once:
  - outputs: pe_inst=0, pe_data=0, pe_valid=0, s_ready=0, prog_err=0, busy=0, prog_len=0, host_inst_ready=1.
  - internal: state=INST, all counters 0.
- Reset mid-operation aborts immediately.
- The PE instruction memory has no address reset, so the system must reset the PE and this block together.
- States: INST -> SETTLE -> DATA <-> GAP. There is no exit from DATA/GAP except rst.
- INST state:
  - host_inst_ready=1.
  - Accepted nonzero word: registered onto pe_inst the next cycle for exactly one cycle, N increments. Otherwise pe_inst=0.
  - Word equal to 0 is dropped with a prog_err pulse; N is unchanged. The PE would silently ignore a zero word.
  - Word accepted when N=2^IM_ADDR_WIDTH-1 is dropped with a prog_err pulse.
  - host_inst_last accepted with N>=1 after the update: go to SETTLE.
  - host_inst_last leaving N=0: prog_err pulse, remain in INST.
- SETTLE state:
  - 2 cycles with pe_inst=0, pe_valid=0. This covers the PE's registered write pipeline.
  - Then go to DATA. host_inst_ready=0 from SETTLE onward.
- DATA state:
  - s_ready=1. Each s_valid&s_ready beat registers pe_data<=s_data, pe_valid<=1 (1-cycle latency); beat count increments.
  - Go to GAP after the BURST_LEN-th beat.
  - If s_valid=0 after at least 1 beat, the burst ends early: go to GAP, because pe_valid falling triggers PE replay.
  - If s_valid=0 with 0 beats, stay in DATA with pe_valid=0.
- GAP state:
  - s_ready=0, pe_valid=0, pe_data holds its last value.
  - Lasts exactly N+GAP_EXTRA cycles counted from the first cycle pe_valid is low, then go to DATA.
  - Gap counter width is IM_ADDR_WIDTH+2 bits; no overflow at N=15, GAP_EXTRA<=15.
- pe_valid timing: never high on two separated runs closer than N+GAP_EXTRA low cycles.
- Simultaneous events:
  - host_inst_valid in DATA/GAP is ignored (ready=0).
  - s_valid in INST/SETTLE/GAP is not accepted.
- prog_len holds N after INST.

Decomposition:
- Shared parameters header: INST_WIDTH, IM_ADDR_WIDTH, DATA_WIDTH; the state encoding localparams go in the same shared header.
- One natural sub-module: inst_stream_tx_gap_ctr, a loadable down-counter with a done flag, used for the SETTLE and GAP waits.
- The rest stays flat.

Test Plan:
- Load 0x11,0x22,0x33 (last on 0x33) -> pe_inst shows 0x11,0x22,0x33 on consecutive cycles then 0; prog_len=3; no prog_err; busy rises.
- Load 0x11,0x0,0x22(last) -> prog_err pulse on the 0x0 cycle; pe_inst never carries 0 as a word; prog_len=2.
- Load 16 nonzero words -> the 16th is dropped with prog_err; prog_len=15.
- N=3, BURST_LEN=8, continuous s_valid, 20 words:
  - pe_valid high for 8 cycles, low for exactly 5, high 8, low 5, high 4 (remaining words).
  - pe_data sequence matches input.
- N=3, s_valid drops after 3 beats -> burst ends, pe_valid low for exactly 5 cycles, s_ready=0 during the gap.
- Assert rst during GAP -> next cycle all outputs at reset values, host_inst_ready=1, state INST.
